conv_mac_pipe: RTL and testbench

Parametrised, pipelined signed multiply-accumulate unit for the CNN conv kernels; the successor to the single-cycle combinational 16x8 DSP multiplier.
- Multiplies a weight/activation pair per accepted beat over NUM_STAGE register stages.
- Accumulates products over a frame delimited by in_last.
- Emits one arithmetic-shifted, saturated result per frame.
- Ready/valid handshakes with full backpressure on both sides; sits between the conv line-buffer/weight streams and the output requantiser.

---
 rtl/conv_mac_pkg.sv | 50 +++++
 rtl/conv_mac_mul_stage.sv | 59 +++++
 rtl/conv_mac_pipe.sv | 143 ++++++++++++++
 tb/tb_conv_mac_pipe.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mac_pkg.sv
// conv_mac_pipe shared types and helpers.
// Product width, saturation range check, accumulate FSM states.
package conv_mac_pkg;

  localparam int MAXW = 128;

  typedef enum logic {
    FIRST,
    ACCUM
  } acc_st_e;

  function automatic int prod_w(
    input int w0,
    input int w1
  );
    return w0 + w1;
  endfunction

  function automatic bit cfg_ok(
    input int w0,
    input int w1,
    input int ns,
    input int acc,
    input int sh,
    input int dw
  );
    return (w0 >= 2) && (w0 <= 32) &&
           (w1 >= 2) && (w1 <= 32) &&
           (ns >= 1) && (ns <= 6) &&
           (acc >= prod_w(w0, w1)) &&
           (acc <= MAXW) &&
           (sh >= 0) && (sh < acc) &&
           (dw >= 2) && (dw <= acc);
  endfunction

  // {over, under} for a signed value against a w-bit signed range
  function automatic logic [1:0] sat_dir(
    input logic signed [MAXW-1:0] v,
    input int w
  );
    logic signed [MAXW-1:0] one;
    logic signed [MAXW-1:0] mx;
    logic signed [MAXW-1:0] mn;
    one = MAXW'(1);
    mx  = (one <<< (w - 1)) - one;
    mn  = ~mx;
    return {(v > mx), (v < mn)};
  endfunction

endpackage

// File: rtl/conv_mac_mul_stage.sv
// Pipelined full-precision signed multiplier with valid/last sideband.
// All stages share one enable so the pipe stalls as a unit.
module conv_mac_mul_stage
  import conv_mac_pkg::*;
#(
  parameter int W0 = 16,
  parameter int W1 = 8,
  parameter int NS = 3,
  localparam int PW = prod_w(W0, W1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic signed [W0-1:0] a,
  input  logic signed [W1-1:0] b,
  output logic                 out_valid,
  output logic                 out_last,
  output logic signed [PW-1:0] out_prod
);

  logic [NS-1:0]         v_q;
  logic [NS-1:0]         l_q;
  logic signed [PW-1:0]  p_q [NS];
  logic signed [PW-1:0]  ax;
  logic signed [PW-1:0]  bx;

  assign ax = PW'(a);
  assign bx = PW'(b);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
    end else if (en) begin
      v_q[0] <= in_valid;
      for (int i = 1; i < NS; i++) begin
        v_q[i] <= v_q[i-1];
      end
    end
  end

  // data regs carry no reset so they map onto DSP pipeline registers
  always_ff @(posedge clk) begin
    if (en) begin
      p_q[0] <= ax * bx;
      l_q[0] <= in_last;
      for (int i = 1; i < NS; i++) begin
        p_q[i] <= p_q[i-1];
        l_q[i] <= l_q[i-1];
      end
    end
  end

  assign out_valid = v_q[NS-1];
  assign out_last  = l_q[NS-1];
  assign out_prod  = p_q[NS-1];

endmodule

// File: rtl/conv_mac_pipe.sv
// Pipelined signed MAC: per-frame accumulate, shift, saturate.
// Whole pipe advances together when the output reg can take data.
module conv_mac_pipe
  import conv_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 8,
  parameter int NUM_STAGE  = 3,
  parameter int ACC_WIDTH  = 32,
  parameter int SHIFT      = 0,
  parameter int DOUT_WIDTH = 24
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         sat
);

  localparam int PW = prod_w(DIN0_WIDTH, DIN1_WIDTH);
  localparam int AM = ACC_WIDTH - 1;

  if (!cfg_ok(DIN0_WIDTH, DIN1_WIDTH, NUM_STAGE,
              ACC_WIDTH, SHIFT, DOUT_WIDTH)) begin : g_bad_cfg
    $error("conv_mac_pipe: illegal parameter set");
  end

  logic                         adv;
  logic                         beat;
  logic                         m_valid;
  logic                         m_last;
  logic signed [PW-1:0]         m_prod;

  acc_st_e                      st_q;
  acc_st_e                      st_d;

  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic signed [ACC_WIDTH-1:0]  base;
  logic signed [ACC_WIDTH-1:0]  addend;
  logic signed [ACC_WIDTH-1:0]  acc_d;
  logic signed [ACC_WIDTH-1:0]  res;
  logic                         ovf_q;
  logic                         ovf_add;
  logic                         ovf_d;

  logic [1:0]                   clip;
  logic signed [DOUT_WIDTH-1:0] dmax;
  logic signed [DOUT_WIDTH-1:0] dval;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign beat     = adv && m_valid;

  conv_mac_mul_stage #(
    .W0 (DIN0_WIDTH),
    .W1 (DIN1_WIDTH),
    .NS (NUM_STAGE)
  ) u_mul (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .en        (adv),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .a         (din0),
    .b         (din1),
    .out_valid (m_valid),
    .out_last  (m_last),
    .out_prod  (m_prod)
  );

  always_comb begin
    st_d = st_q;
    if (beat) begin
      unique case (st_q)
        FIRST:   st_d = m_last ? FIRST : ACCUM;
        ACCUM:   st_d = m_last ? FIRST : ACCUM;
        default: st_d = FIRST;
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      st_q <= FIRST;
    end else begin
      st_q <= st_d;
    end
  end

  // a frame start adds onto zero, so it can never overflow
  assign addend  = ACC_WIDTH'(m_prod);
  assign base    = (st_q == ACCUM) ? acc_q : '0;
  assign acc_d   = base + addend;
  assign ovf_add = (base[AM] == addend[AM]) &&
                   (acc_d[AM] != base[AM]);
  assign ovf_d   = ((st_q == ACCUM) && ovf_q) || ovf_add;

  assign res  = acc_d >>> SHIFT;
  assign clip = sat_dir(MAXW'(res), DOUT_WIDTH);
  assign dmax = {1'b0, {(DOUT_WIDTH-1){1'b1}}};

  always_comb begin
    dval = res[DOUT_WIDTH-1:0];
    unique case (1'b1)
      clip[1]: dval = dmax;
      clip[0]: dval = ~dmax;
      default: dval = res[DOUT_WIDTH-1:0];
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (beat) begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      sat       <= 1'b0;
    end else if (adv) begin
      if (beat && m_last) begin
        out_valid <= 1'b1;
        dout      <= dval;
        sat       <= (|clip) || ovf_d;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Randomised + directed bench for conv_mac_pipe against a frame-level model.
// Two instances (SHIFT 0 and 4) share one input stream.
module tb_conv_mac_pipe;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_last = 1'b0;
  logic               out_ready = 1'b1;
  logic signed [15:0] din0 = '0;
  logic signed [7:0]  din1 = '0;

  logic               in_ready0, in_ready4;
  logic               out_valid0, out_valid4;
  logic               sat0, sat4;
  logic signed [23:0] dout0, dout4;

  always #5 ap_clk = ~ap_clk;

  conv_mac_pipe #(.SHIFT(0)) dut0 (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .din0      (din0),
    .din1      (din1),
    .in_last   (in_last),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .dout      (dout0),
    .sat       (sat0)
  );

  conv_mac_pipe #(.SHIFT(4)) dut4 (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .din0      (din0),
    .din1      (din1),
    .in_last   (in_last),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .dout      (dout4),
    .sat       (sat4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // frame-level reference: 32-bit wrapping sum, sticky overflow
  int     wacc = 0;
  bit     movf = 0;
  bit     mfirst = 1;
  longint exp_d0[$];
  bit     exp_s0[$];
  longint exp_d4[$];
  bit     exp_s4[$];

  function automatic void push_res(input int sh);
    longint r;
    longint d;
    bit     s;
    r = longint'(wacc) >>> sh;
    if (r > 8388607) begin
      d = 8388607;
      s = 1;
    end else if (r < -8388608) begin
      d = -8388608;
      s = 1;
    end else begin
      d = r;
      s = movf;
    end
    if (sh == 0) begin
      exp_d0.push_back(d);
      exp_s0.push_back(s);
    end else begin
      exp_d4.push_back(d);
      exp_s4.push_back(s);
    end
  endfunction

  function automatic void model_beat(input int a, input int b,
                                     input bit l);
    longint p;
    longint nv;
    p = longint'(a) * longint'(b);
    if (mfirst) begin
      nv   = p;
      movf = 0;
    end else begin
      nv = longint'(wacc) + p;
    end
    if (nv > 64'sd2147483647 || nv < -64'sd2147483648)
      movf = 1;
    wacc = int'(nv);
    if (l) begin
      push_res(0);
      push_res(4);
    end
    mfirst = l;
  endfunction

  // output monitor and hold-stability checks
  bit                 stall0 = 0;
  bit                 stall4 = 0;
  logic signed [23:0] hold0, hold4;
  longint             last_d0 = 0;
  longint             last_d4 = 0;
  bit                 last_s0 = 0;
  bit                 last_s4 = 0;
  int                 n_out0 = 0;

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      stall0 = 0;
      stall4 = 0;
    end else begin
      if (stall0) begin
        chk("hold_valid0", out_valid0, 1);
        chk("hold_dout0", dout0, hold0);
      end
      if (stall4) chk("hold_dout4", dout4, hold4);
      stall0 = out_valid0 && !out_ready;
      stall4 = out_valid4 && !out_ready;
      hold0  = dout0;
      hold4  = dout4;
      if (out_valid0 && out_ready) begin
        n_out0++;
        if (exp_d0.size() == 0) begin
          chk("extra_out0", 1, 0);
        end else begin
          chk("dout0", dout0, exp_d0.pop_front());
          chk("sat0", sat0, exp_s0.pop_front());
        end
        last_d0 = dout0;
        last_s0 = sat0;
      end
      if (out_valid4 && out_ready) begin
        if (exp_d4.size() == 0) begin
          chk("extra_out4", 1, 0);
        end else begin
          chk("dout4", dout4, exp_d4.pop_front());
          chk("sat4", sat4, exp_s4.pop_front());
        end
        last_d4 = dout4;
        last_s4 = sat4;
      end
    end
  end

  bit rnd_bp = 0;

  initial begin
    forever begin
      @(posedge ap_clk);
      #1;
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // called at posedge+1; returns at posedge+1 after the transfer
  task automatic send_beat(input logic signed [15:0] a,
                           input logic signed [7:0] b,
                           input logic l);
    int n;
    in_valid = 1'b1;
    din0     = a;
    din1     = b;
    in_last  = l;
    n = 0;
    forever begin
      @(negedge ap_clk);
      if (in_ready0) break;
      n++;
      if (n > 500) begin
        chk("in_ready_timeout", 0, 1);
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge ap_clk);
    model_beat(int'(a), int'(b), l);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_d0.size() != 0 || exp_d4.size() != 0) && n < 400) begin
      @(posedge ap_clk);
      n++;
    end
    if (n >= 400) chk("drain_timeout", exp_d0.size(), 0);
    repeat (2) @(posedge ap_clk);
    #1;
  endtask

  logic signed [15:0] ra;
  logic signed [7:0]  rb;
  int                 base_n;
  int                 lat;
  int                 flen;
  int                 gap;
  bit                 saw_drop;

  initial begin
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_valid", out_valid0, 0);
    chk("rst_dout", dout0, 0);
    chk("rst_sat", sat0, 0);
    chk("rst_ready", in_ready0, 1);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;

    send_beat(-16'sd32768, -8'sd128, 1'b1);
    lat = 0;
    while (!out_valid0 && lat < 20) begin
      @(posedge ap_clk);
      lat++;
      @(negedge ap_clk);
    end
    chk("latency", lat + 1, 4);
    drain();
    chk("single_d", last_d0, 4194304);
    chk("single_s", last_s0, 0);

    send_beat(16'sd100, 8'sd2, 1'b0);
    send_beat(-16'sd50, 8'sd3, 1'b0);
    send_beat(16'sd7, -8'sd1, 1'b1);
    drain();
    chk("frame43_d0", last_d0, 43);
    chk("frame43_d4", last_d4, 2);

    send_beat(-16'sd100, 8'sd2, 1'b0);
    send_beat(16'sd50, 8'sd3, 1'b0);
    send_beat(-16'sd7, -8'sd1, 1'b1);
    send_beat(16'sd1, 8'sd1, 1'b1);
    drain();
    chk("restart_d0", last_d0, 1);

    send_beat(-16'sd100, 8'sd2, 1'b0);
    send_beat(16'sd50, 8'sd3, 1'b0);
    send_beat(-16'sd7, -8'sd1, 1'b1);
    drain();
    chk("floor_d4", last_d4, -3);

    for (int i = 0; i < 3; i++) send_beat(16'sd32767, 8'sd127, i == 2);
    drain();
    chk("satpos_d", last_d0, 8388607);
    chk("satpos_s", last_s0, 1);

    for (int i = 0; i < 3; i++) send_beat(-16'sd32768, 8'sd127, i == 2);
    drain();
    chk("satneg_d", last_d0, -8388608);
    chk("satneg_s", last_s0, 1);

    for (int i = 0; i < 600; i++) send_beat(-16'sd32768, -8'sd128, i == 599);
    drain();
    chk("accovf_s", last_s0, 1);
    chk("accovf_s4", last_s4, 1);

    base_n    = n_out0;
    saw_drop  = 0;
    out_ready = 1'b0;
    fork
      begin
        send_beat(16'sd10, 8'sd2, 1'b0);
        send_beat(16'sd5, -8'sd3, 1'b1);
        send_beat(-16'sd7, 8'sd7, 1'b0);
        send_beat(16'sd100, 8'sd1, 1'b1);
      end
      begin
        repeat (8) begin
          @(negedge ap_clk);
          if (!in_ready0) saw_drop = 1;
        end
        @(posedge ap_clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_ready_drop", saw_drop, 1);
    chk("bp_count", n_out0 - base_n, 2);
    chk("bp_last", last_d0, 51);

    send_beat(16'sd5, 8'sd5, 1'b0);
    send_beat(16'sd6, 8'sd6, 1'b0);
    ap_rst_n = 1'b0;
    mfirst   = 1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_mid_valid", out_valid0, 0);
    chk("rst_mid_dout", dout0, 0);
    #1;
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("rst_post_valid", out_valid0, 0);
    chk("rst_post_dout", dout0, 0);
    @(posedge ap_clk);
    #1;
    base_n = n_out0;
    send_beat(16'sd3, 8'sd3, 1'b1);
    drain();
    chk("rst_frame_d", last_d0, 9);
    chk("rst_frame_n", n_out0 - base_n, 1);

    base_n = n_out0;
    rnd_bp = 1;
    for (int f = 0; f < 60; f++) begin
      flen = $urandom_range(1, 5);
      for (int k = 0; k < flen; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          ra = $urandom_range(0, 1) ? 16'sh7fff : 16'sh8000;
          rb = $urandom_range(0, 1) ? 8'sh7f : 8'sh80;
        end else begin
          ra = 16'($urandom);
          rb = 8'($urandom);
        end
        send_beat(ra, rb, k == flen - 1);
        gap = $urandom_range(0, 2);
        if (gap != 0) begin
          repeat (gap) @(posedge ap_clk);
          #1;
        end
      end
    end
    rnd_bp    = 0;
    out_ready = 1'b1;
    drain();
    chk("rnd_count", n_out0 - base_n, 60);
    chk("rnd_left4", exp_d4.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
